// File: rtl/spi_target_pkg.sv
//----------------------------------------------------------------------------
// Module      : spi_target_pkg
// Description : Shared widths and state encoding for the SPI mode-0 target.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package spi_target_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 4;

    // Two-state frame FSM, explicitly one bit wide.
    typedef logic [0:0] state_t;
    localparam state_t c_ST_IDLE  = 1'b0;
    localparam state_t c_ST_SHIFT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spi_target_sync.sv
//----------------------------------------------------------------------------
// Module      : spi_target_sync
// Description : 1-bit synchroniser chain of STAGES flops with a selectable
//               asynchronous reset value. STAGES=0 passes the pin through.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module spi_target_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] r_chain;

            // Shift the pin through the flop chain; oldest sample drives q.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_chain <= {STAGES{RESET_VAL}};
                end else begin
                    r_chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end

            assign q = r_chain[STAGES-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_target.sv
//----------------------------------------------------------------------------
// Module      : spi_target
// Description : SPI mode-0 target. Oversamples sck/cs/mosi in the clk domain,
//               deserialises MSB-first bytes into a 1-entry RX holder and
//               serialises bytes from a 1-entry TX holder onto spi_miso.
//               Optional macro SPI_TARGET_ECHO_EN: with an empty TX holder at
//               a byte reload, the last byte stored into rx_data is sent
//               instead of TX_IDLE.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module spi_target
    import spi_target_pkg::*;
#(
    parameter int              SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] TX_IDLE   = 8'hff
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
);

    logic w_sck, w_cs, w_mosi;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .resetn(resetn), .d(spi_clk), .q(w_sck));
    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .resetn(resetn), .d(spi_cs), .q(w_cs));
    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetn(resetn), .d(spi_mosi), .q(w_mosi));

    logic r_sck_prev, r_cs_prev;

    // Previous synced levels for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sck_prev <= 1'b0;
            r_cs_prev  <= 1'b1;
        end else begin
            r_sck_prev <= w_sck;
            r_cs_prev  <= w_cs;
        end
    end

    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_cs_fall  = ~w_cs & r_cs_prev;
    assign w_cs_rise  = w_cs & ~r_cs_prev;

    state_t r_state, w_state_next;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_ST_IDLE;
        else         r_state <= w_state_next;
    end

    // FSM next state: frame opens on cs falling, closes on cs rising.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_cs_fall) w_state_next = c_ST_SHIFT;
            c_ST_SHIFT: if (w_cs_rise) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (r_state == c_ST_SHIFT);
    end

    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [BYTE_W-2:0]    r_rx_shift;   // last 7 bits received; bit 8 comes from the pin
    logic [BYTE_W-2:0]    r_tx_shift;   // bits still to send after the one on spi_miso
    logic                 r_miso;
    logic [BYTE_W-1:0]    r_tx_hold;
    logic                 r_tx_full;
    logic [BYTE_W-1:0]    r_rx_data;
    logic                 r_rx_valid;
    logic                 r_overrun;

    logic              w_start, w_abort, w_rise, w_fall;
    logic              w_byte_done, w_reload, w_shift_out, w_tx_fire;
    logic [BYTE_W-1:0] w_rx_byte, w_idle_byte, w_reload_byte;

    // A cs rising edge preempts any sck activity in the same clk.
    assign w_start     = (r_state == c_ST_IDLE) & w_cs_fall;
    assign w_abort     = (r_state == c_ST_SHIFT) & w_cs_rise;
    assign w_rise      = (r_state == c_ST_SHIFT) & ~w_cs_rise & w_sck_rise;
    assign w_fall      = (r_state == c_ST_SHIFT) & ~w_cs_rise & w_sck_fall;
    assign w_byte_done = w_rise & (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1));
    // bit_cnt==0 on a falling edge means the previous byte just completed.
    assign w_reload    = w_start | (w_fall & (r_bit_cnt == '0));
    assign w_shift_out = w_fall & (r_bit_cnt != '0);
    assign w_tx_fire   = tx_valid & ~r_tx_full;
    assign w_rx_byte   = {r_rx_shift, w_mosi};

`ifdef SPI_TARGET_ECHO_EN
    assign w_idle_byte = r_rx_data;
`else
    assign w_idle_byte = TX_IDLE;
`endif

    // Held byte first, then a same-clk offer (bypass), then the filler byte.
    assign w_reload_byte = r_tx_full ? r_tx_hold : (w_tx_fire ? tx_data : w_idle_byte);

    // Receive side: bit counter and input shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else if (w_start || w_abort) begin
            r_bit_cnt  <= '0;
        end else if (w_rise) begin
            r_rx_shift <= w_rx_byte[BYTE_W-2:0];
            r_bit_cnt  <= w_byte_done ? '0 : r_bit_cnt + BIT_CNT_W'(1);
        end
    end

    // Transmit side: output shift register and registered miso.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_shift <= '0;
            r_miso     <= 1'b1;
        end else if (w_abort) begin
            r_miso     <= 1'b1;
        end else if (w_reload) begin
            r_tx_shift <= w_reload_byte[BYTE_W-2:0];
            r_miso     <= w_reload_byte[BYTE_W-1];
        end else if (w_shift_out) begin
            r_tx_shift <= {r_tx_shift[BYTE_W-3:0], 1'b0};
            r_miso     <= r_tx_shift[BYTE_W-2];
        end
    end

    // TX holding register: emptied by a reload, filled by a handshake unless
    // that handshake bypassed straight into the shifter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_hold <= '0;
            r_tx_full <= 1'b0;
        end else if (w_reload && r_tx_full) begin
            r_tx_full <= 1'b0;
        end else if (w_tx_fire && !w_reload) begin
            r_tx_hold <= tx_data;
            r_tx_full <= 1'b1;
        end
    end

    // RX holding register: a same-clk consume frees the slot for the new byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_byte_done && (!r_rx_valid || rx_ready)) begin
            r_rx_data  <= w_rx_byte;
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new overrun wins over a same-clk clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                      r_overrun <= 1'b0;
        else if (w_byte_done && r_rx_valid && !rx_ready)  r_overrun <= 1'b1;
        else if (overrun_clr)                             r_overrun <= 1'b0;
    end

    assign spi_miso = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_ready = ~r_tx_full;
    assign overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_target.sv
//----------------------------------------------------------------------------
// Module      : tb_spi_target
// Description : Self-checking bench for spi_target (SYNC_STAGES=0): a vector
//               table of single-byte frames, hand-written corner sequences,
//               and random multi-byte frames against a transaction model.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_spi_target;

    logic       clk = 1'b0;
    logic       resetn;
    logic       spi_clk, spi_cs, spi_mosi, spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, busy, overrun, overrun_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(0), .TX_IDLE(8'hff)) dut (
        .clk(clk), .resetn(resetn),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Initiator: one byte MSB first, mode 0, half-period hp clks. The bit on
    // miso is captured as sck rises. Ends one clk after the final falling edge.
    task automatic xfer(input logic [7:0] mo, input int nbits, input int hp, input bit pulse_last,
                        output logic [7:0] mi, output logic v_rise, output logic v_after);
        mi = 8'h00; v_rise = 1'b0; v_after = 1'b0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = mo[i];
            tick(hp);
            spi_clk = 1'b1;
            mi[i]   = spi_miso;
            if (i == 0) begin
                v_rise = rx_valid;
                if (pulse_last) rx_ready = 1'b1;
            end
            tick(1);
            if (i == 0) begin
                rx_ready = 1'b0;
                v_after  = rx_valid;
            end
            tick(hp - 1);
            spi_clk = 1'b0;
        end
        tick(1);
    endtask

    task automatic cs_start();
        spi_cs = 1'b0;
        tick(2);
    endtask

    task automatic cs_end();
        tick(1);
        spi_cs = 1'b1;
        tick(3);
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [7:0] m_rx_data, m_tx_hold;
    bit         m_rx_valid, m_ovr, m_tx_full;

    task automatic m_reset();
        m_rx_data = 8'h00; m_rx_valid = 0; m_ovr = 0; m_tx_full = 0; m_tx_hold = 8'h00;
    endtask

    // Byte the target will send in the next byte slot.
    task automatic m_reload(output logic [7:0] v);
        if (m_tx_full) begin
            v = m_tx_hold;
            m_tx_full = 0;
        end else begin
`ifdef SPI_TARGET_ECHO_EN
            v = m_rx_data;
`else
            v = 8'hff;
`endif
        end
    endtask

    task automatic m_complete(input logic [7:0] b);
        if (!m_rx_valid) begin
            m_rx_data  = b;
            m_rx_valid = 1;
        end else begin
            m_ovr = 1;
        end
    endtask

    task automatic offer_tx(input logic [7:0] b);
        tx_data = b; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        if (!m_tx_full) begin
            m_tx_hold = b;
            m_tx_full = 1;
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        m_rx_valid = 0;
    endtask

    task automatic clear_ovr();
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        m_ovr = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
        m_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] mosi;
        bit         pre;
        logic [7:0] txb;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] mi, mi2, exp_b, b;
        logic       vr, va;
        int         nb, hp;

        resetn = 1'b0; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; overrun_clr = 1'b0;
        m_reset();
        tick(3);

        check("rst_miso",     spi_miso, 1);
        check("rst_rx_data",  rx_data,  0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy",     busy,     0);
        check("rst_overrun",  overrun,  0);
        resetn = 1'b1;
        tick(2);

`ifdef SPI_TARGET_ECHO_EN
        vecs[0] = '{8'hA5, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'hFF, 1'b0, 8'h00, 8'h5A};
`else
        vecs[0] = '{8'hA5, 1'b0, 8'h00, 8'hFF};
        vecs[3] = '{8'hFF, 1'b0, 8'h00, 8'hFF};
`endif
        vecs[1] = '{8'h00, 1'b1, 8'h3C, 8'h3C};
        vecs[2] = '{8'h5A, 1'b1, 8'hC3, 8'hC3};
        vecs[4] = '{8'h96, 1'b1, 8'h00, 8'h00};

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].pre) begin
                tx_data = vecs[v].txb; tx_valid = 1'b1;
                tick(1);
                tx_valid = 1'b0;
                check("vec_tx_ready_full", tx_ready, 0);
            end
            cs_start();
            check("vec_busy", busy, 1);
            check("vec_tx_ready_after_load", tx_ready, 1);
            xfer(vecs[v].mosi, 8, 1, 0, mi, vr, va);
            check("vec_valid_at_last_rise", vr, 0);
            check("vec_valid_one_clk_later", va, 1);
            check("vec_miso_byte", mi, vecs[v].exp_miso);
            check("vec_rx_data", rx_data, vecs[v].mosi);
            cs_end();
            check("vec_busy_end", busy, 0);
            consume();
            check("vec_rx_valid_consumed", rx_valid, 0);
        end

        // Overrun: second byte dropped, clear leaves rx_data alone.
        cs_start();
        xfer(8'h11, 8, 1, 0, mi, vr, va);
        xfer(8'h22, 8, 1, 0, mi, vr, va);
        cs_end();
        check("ovr_rx_data", rx_data, 8'h11);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", rx_valid, 1);
        overrun_clr = 1'b1; tick(1); overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        check("ovr_rx_data_kept", rx_data, 8'h11);
        consume();

        // Consume in the very clk the second byte completes: no overrun.
        cs_start();
        xfer(8'h11, 8, 1, 0, mi, vr, va);
        xfer(8'h22, 8, 1, 1, mi, vr, va);
        cs_end();
        check("same_clk_rx_data", rx_data, 8'h22);
        check("same_clk_overrun", overrun, 0);
        check("same_clk_valid", rx_valid, 1);
        consume();

        // Abort after 5 bits, then a clean frame.
        cs_start();
        xfer(8'hF0, 5, 1, 0, mi, vr, va);
        cs_end();
        check("abort_valid", rx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_miso", spi_miso, 1);
        check("abort_overrun", overrun, 0);
        cs_start();
        xfer(8'h5A, 8, 1, 0, mi, vr, va);
        cs_end();
        check("after_abort_rx", rx_data, 8'h5A);
        check("after_abort_valid", rx_valid, 1);
        consume();

        // Two-byte frame, no TX data: second slot is filler or echo.
        cs_start();
        xfer(8'h81, 8, 1, 0, mi, vr, va);
        xfer(8'h00, 8, 1, 0, mi2, vr, va);
        cs_end();
`ifdef SPI_TARGET_ECHO_EN
        check("second_slot_miso", mi2, 8'h81);
`else
        check("second_slot_miso", mi2, 8'hFF);
`endif
        consume();
        if (overrun) overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;

        // Random frames against the model.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 3);
            hp = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) offer_tx(8'($urandom));
            cs_start();
            m_reload(exp_b);
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                xfer(b, 8, hp, 0, mi, vr, va);
                m_complete(b);
                check("rnd_miso", mi, exp_b);
                check("rnd_rx_data", rx_data, m_rx_data);
                check("rnd_rx_valid", rx_valid, m_rx_valid);
                check("rnd_overrun", overrun, m_ovr);
                m_reload(exp_b);
                check("rnd_tx_ready", tx_ready, !m_tx_full);
                if ($urandom_range(0, 1) == 1) consume();
                if ($urandom_range(0, 2) == 0) offer_tx(8'($urandom));
            end
            cs_end();
            check("rnd_busy_end", busy, 0);
            check("rnd_miso_end", spi_miso, 1);
            if ($urandom_range(0, 2) == 0) clear_ovr();
        end

        // Reset mid-byte with non-reset state present.
        cs_start();
        xfer(8'h77, 8, 1, 0, mi, vr, va);
        xfer(8'h66, 8, 1, 0, mi, vr, va);
        cs_end();
        offer_tx(8'h42);
        cs_start();
        offer_tx(8'h24);
        xfer(8'h0F, 4, 1, 0, mi, vr, va);
        spi_clk = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_miso",     spi_miso, 1);
        check("midrst_rx_data",  rx_data,  0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_busy",     busy,     0);
        check("midrst_overrun",  overrun,  0);
        spi_clk = 1'b0; spi_cs = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(2);
        cs_start();
        xfer(8'hC5, 8, 2, 0, mi, vr, va);
        cs_end();
        check("post_rst_rx", rx_data, 8'hC5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 target (responder): the far end of the SoC's MMIO-driven SPI initiator.
- Oversamples spi_clk, spi_cs and spi_mosi in the system clock domain and deserialises MSB-first bytes into a 1-entry RX holding register with valid/ready handshake.
- Serialises bytes from a 1-entry TX holding register onto spi_miso.
- Used as a bench peer for the initiator and as a board-level SPI target.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on spi_clk/spi_cs/spi_mosi. Legal range 0..3; 0 means pins are used directly.
- TX_IDLE, 8'hff, byte shifted out when no TX byte is held at frame/byte start.

Ports:
- clk  in  1  system clock, all state on posedge.
- resetn  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI clock from initiator, idle low.
- spi_cs  in  1  chip select, active low.
- spi_mosi  in  1  initiator-to-target data.
- spi_miso  out  1  target-to-initiator data, registered.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid&&rx_ready.
- tx_data  in  8  next byte to send.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  TX holding register empty. Transfer happens on tx_valid&&tx_ready.
- busy  out  1  frame active (synchronised cs low).
- overrun  out  1  sticky: a byte completed while rx_valid was high.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values: spi_miso=1, rx_data=0, rx_valid=0, tx_ready=1, busy=0, overrun=0. Bit counter=0, shift registers=0.
- Synchronise: SYNC_STAGES flops per input, then one "prev" register each for sck and cs. Edge detection compares the synced value against prev.
  - Pin-to-detect latency is SYNC_STAGES+1 clk.
  - Each sck level must last ≥1 clk after synchronisation. With SYNC_STAGES=0 the block works with an initiator toggling spi_clk every clk.
- States: IDLE, SHIFT.
  - IDLE -> SHIFT on cs falling edge (synced). Load tx_shift from the TX holding register if full (tx_ready goes 1 the next clk), else TX_IDLE. spi_miso <= bit7 next clk. bit_cnt=0.
  - SHIFT, sck rising: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - SHIFT, sck falling with bit_cnt in 1..7: tx_shift <= tx_shift<<1; spi_miso <= new bit7.
  - SHIFT, rising edge that makes bit_cnt=8: byte complete.
    - If rx_valid=0, or rx_ready is consumed in the same clk: rx_data <= completed byte, rx_valid <= 1.
    - Else set overrun and discard the byte; rx_data is unchanged.
    - Reset bit_cnt to 0. At the following sck falling edge, reload tx_shift (TX holding register or TX_IDLE) and drive its bit7.
  - SHIFT -> IDLE on cs rising edge (synced), from any bit_cnt. A partial byte is discarded with no rx_valid and no overrun. spi_miso <= 1. A TX byte loaded for the aborted byte is lost.
- Simultaneous events:
  - Byte completes in the same clk as rx_valid&&rx_ready: the consume happens first, the new byte is stored, no overrun.
  - overrun_clr in the same clk as a new overrun: set wins.
  - tx handshake in the same clk as a reload: the reload takes the old held byte (if any). The offered byte fills the holder only if it was empty before the reload. With tx_ready=1, a same-clk load bypasses directly into tx_shift.
- sck edges while in IDLE are ignored. busy = (state==SHIFT).
- Reset asserted mid-frame: all state returns to reset values immediately (async). A frame in progress is abandoned.

Optional Feature:
- Macro: SPI_TARGET_ECHO_EN.
- Defined: when the TX holder is empty at a byte reload, send the last byte stored into rx_data (reset 0) instead of TX_IDLE.
- Undefined: send TX_IDLE.

Decomposition:
- Package spi_target_pkg: state enum (IDLE, SHIFT), BYTE_W=8, BIT_CNT_W=4.
- Sub-module spi_target_sync: parameterised SYNC_STAGES flop chain, 1 bit, async reset value as a parameter. Reset values: cs=1, sck=0, mosi=0.

Test Plan:
- SYNC_STAGES=0, no TX byte; initiator sends 8'hA5 with cs low, sck half-period 1 clk -> rx_data=8'hA5, rx_valid=1 after 8th rising edge +1 clk; miso bits sampled by initiator = 8'hFF.
- Preload tx_data=8'h3C before cs falls; send 8'h00 -> initiator samples 8'h3C on miso; tx_ready=1 again after the load.
- Two bytes 8'h11, 8'h22 with rx_ready=0 -> rx_data=8'h11, overrun=1. overrun_clr -> overrun=0, rx_data still 8'h11.
- Same two bytes with rx_ready pulsed in the clk the second byte completes -> rx_data=8'h22, overrun=0.
- cs deasserted after 5 bits -> no rx_valid, busy=0, miso=1. Next full frame 8'h5A received correctly.
- SPI_TARGET_ECHO_EN defined; two-byte frame 8'h81, 8'h00 with no TX data -> second byte on miso = 8'h81. Assert resetn low mid-byte -> all outputs at reset values.
